// File: rtl/vx_tlb_pkg.sv
// vx_tlb shared types: command encoding and field widths.
// Imported by the TLB top and its way sub-module.
package vx_tlb_pkg;

  typedef enum logic [1:0] {
    TLB_CMD_NONE       = 2'd0,
    TLB_CMD_RESOLVE    = 2'd1,
    TLB_CMD_WRITE      = 2'd2,
    TLB_CMD_INVALIDATE = 2'd3
  } tlb_cmd_e;

  localparam int VPN_W = 20;
  localparam int PPN_W = 22;
  localparam int ACC_W = 8;

endpackage

// File: rtl/vx_tlb_way.sv
// One TLB way: per-set valid/tag/data storage,
// write-set probe and read-set compare.
module vx_tlb_way
  import vx_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ENTRIES_W-1:0]       wr_set,
  input  logic [VPN_W-ENTRIES_W-1:0] wr_tag,
  input  logic [ACC_W-1:0]           wr_acc,
  input  logic [PPN_W-1:0]           wr_phys,
  input  logic                       inv_en,
  input  logic [ENTRIES_W-1:0]       inv_set,
  input  logic [ENTRIES_W-1:0]       rd_set,
  input  logic [VPN_W-ENTRIES_W-1:0] rd_tag,
  output logic                       wr_valid,
  output logic                       wr_hit,
  output logic                       rd_hit,
  output logic [ACC_W-1:0]           rd_acc,
  output logic [PPN_W-1:0]           rd_phys
);

  localparam int SETS  = 1 << ENTRIES_W;
  localparam int TAG_W = VPN_W - ENTRIES_W;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [ACC_W-1:0] acc_q  [SETS];
  logic [PPN_W-1:0] phys_q [SETS];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid <= '0;
    end else if (inv_en) begin
      valid[inv_set] <= 1'b0;
    end else if (wr_en) begin
      valid[wr_set] <= 1'b1;
    end
  end

  // Payload needs no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_set]  <= wr_tag;
      acc_q[wr_set]  <= wr_acc;
      phys_q[wr_set] <= wr_phys;
    end
  end

  assign wr_valid = valid[wr_set];
  assign wr_hit   = valid[wr_set] && (tag_q[wr_set] == wr_tag);
  assign rd_hit   = valid[rd_set] && (tag_q[rd_set] == rd_tag);
  assign rd_acc   = acc_q[rd_set];
  assign rd_phys  = phys_q[rd_set];

endmodule

// File: rtl/vx_tlb.sv
// Set-associative Sv32-style TLB: registered lookup,
// same-tag/invalid/round-robin fill, per-set invalidate.
module vx_tlb
  import vx_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 1,
  parameter int WAYS_W    = 1,
  parameter bit DEBUG     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           command,
  input  logic [ENTRIES_W-1:0] invalidate_set_index,
  input  logic [VPN_W-1:0]     virtual_address,
  input  logic [VPN_W-1:0]     virtual_address_w,
  input  logic [ACC_W-1:0]     accesstag_w,
  input  logic [PPN_W-1:0]     phys_w,
  output logic                 hit,
  output logic [ACC_W-1:0]     accesstag_r,
  output logic [PPN_W-1:0]     phys_r
);

  localparam int WAYS  = 1 << WAYS_W;
  localparam int SETS  = 1 << ENTRIES_W;
  localparam int TAG_W = VPN_W - ENTRIES_W;

  logic unused_debug;
  assign unused_debug = DEBUG;

  logic do_res, do_wr, do_inv;

  always_comb begin
    do_res = 1'b0;
    do_wr  = 1'b0;
    do_inv = 1'b0;
    unique case (1'b1)
      command == TLB_CMD_RESOLVE:    do_res = 1'b1;
      command == TLB_CMD_WRITE:      do_wr  = 1'b1;
      command == TLB_CMD_INVALIDATE: do_inv = 1'b1;
      default: ;
    endcase
  end

  logic                 rd_pend;
  logic [ENTRIES_W-1:0] rd_set_q;
  logic [TAG_W-1:0]     rd_tag_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_pend  <= 1'b0;
      rd_set_q <= '0;
      rd_tag_q <= '0;
    end else begin
      rd_pend <= do_res;
      if (do_res) begin
        rd_set_q <= virtual_address[ENTRIES_W-1:0];
        rd_tag_q <= virtual_address[VPN_W-1:ENTRIES_W];
      end
    end
  end

  logic [ENTRIES_W-1:0] wr_set;
  logic [TAG_W-1:0]     wr_tag;

  assign wr_set = virtual_address_w[ENTRIES_W-1:0];
  assign wr_tag = virtual_address_w[VPN_W-1:ENTRIES_W];

  logic [WAYS-1:0]  way_wr;
  logic [WAYS-1:0]  w_valid, w_hit, r_hit;
  logic [ACC_W-1:0] r_acc  [WAYS];
  logic [PPN_W-1:0] r_phys [WAYS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    vx_tlb_way #(
      .ENTRIES_W(ENTRIES_W)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (way_wr[g]),
      .wr_set  (wr_set),
      .wr_tag  (wr_tag),
      .wr_acc  (accesstag_w),
      .wr_phys (phys_w),
      .inv_en  (do_inv),
      .inv_set (invalidate_set_index),
      .rd_set  (rd_set_q),
      .rd_tag  (rd_tag_q),
      .wr_valid(w_valid[g]),
      .wr_hit  (w_hit[g]),
      .rd_hit  (r_hit[g]),
      .rd_acc  (r_acc[g]),
      .rd_phys (r_phys[g])
    );
  end

  logic [WAYS_W-1:0] victim [SETS];
  logic [WAYS_W-1:0] hit_way, free_way, sel_way;
  logic              any_hit, any_free, use_victim;

  // Descending scan so the lowest index wins.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    any_hit  = 1'b0;
    any_free = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        any_hit = 1'b1;
        hit_way = WAYS_W'(i);
      end
      if (!w_valid[i]) begin
        any_free = 1'b1;
        free_way = WAYS_W'(i);
      end
    end
    use_victim = !any_hit && !any_free;
    sel_way    = any_hit  ? hit_way  :
                 any_free ? free_way : victim[wr_set];
  end

  always_comb begin
    way_wr = '0;
    if (do_wr) way_wr[sel_way] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int s = 0; s < SETS; s++) victim[s] <= '0;
    end else if (do_inv) begin
      victim[invalidate_set_index] <= '0;
    end else if (do_wr && use_victim) begin
      victim[wr_set] <= victim[wr_set] + 1'b1;
    end
  end

  always_comb begin
    hit         = 1'b0;
    accesstag_r = '0;
    phys_r      = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (rd_pend && r_hit[i]) begin
        hit         = 1'b1;
        accesstag_r = r_acc[i];
        phys_r      = r_phys[i];
      end
    end
  end

endmodule

// File: tb/tb_vx_tlb.sv
// Directed table-driven bench for vx_tlb (2 sets x 2 ways).
// Plus hand sequences for reset during a pending lookup.
module tb_vx_tlb;
  import vx_tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  command;
  logic [0:0]  invalidate_set_index;
  logic [19:0] virtual_address;
  logic [19:0] virtual_address_w;
  logic [7:0]  accesstag_w;
  logic [21:0] phys_w;
  logic        hit;
  logic [7:0]  accesstag_r;
  logic [21:0] phys_r;

  vx_tlb #(
    .ENTRIES_W(1),
    .WAYS_W   (1),
    .DEBUG    (1'b0)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .command             (command),
    .invalidate_set_index(invalidate_set_index),
    .virtual_address     (virtual_address),
    .virtual_address_w   (virtual_address_w),
    .accesstag_w         (accesstag_w),
    .phys_w              (phys_w),
    .hit                 (hit),
    .accesstag_r         (accesstag_r),
    .phys_r              (phys_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [19:0] va;
    logic [7:0]  acc;
    logic [21:0] phys;
    logic        eh;
    logic [7:0]  eacc;
    logic [21:0] ephys;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic [1:0] c, logic [19:0] va,
                              logic [7:0] a, logic [21:0] p,
                              logic eh, logic [7:0] ea,
                              logic [21:0] ep);
    vec_t v;
    v.cmd = c; v.va = va; v.acc = a; v.phys = p;
    v.eh = eh; v.eacc = ea; v.ephys = ep;
    vecs.push_back(v);
  endfunction

  function automatic void wr(logic [19:0] va, logic [7:0] a,
                             logic [21:0] p);
    add(TLB_CMD_WRITE, va, a, p, 1'b0, 8'h0, 22'h0);
  endfunction

  function automatic void rs(logic [19:0] va, logic eh,
                             logic [7:0] ea, logic [21:0] ep);
    add(TLB_CMD_RESOLVE, va, 8'h0, 22'h0, eh, ea, ep);
  endfunction

  function automatic void inv(logic [19:0] s);
    add(TLB_CMD_INVALIDATE, s, 8'h0, 22'h0, 1'b0, 8'h0, 22'h0);
  endfunction

  task automatic apply(vec_t v);
    command              = v.cmd;
    virtual_address      = v.va;
    virtual_address_w    = v.va;
    invalidate_set_index = v.va[0:0];
    accesstag_w          = v.acc;
    phys_w               = v.phys;
  endtask

  task automatic chk(string name, logic eh, logic [7:0] ea,
                     logic [21:0] ep);
    checks++;
    if (hit !== eh || accesstag_r !== ea || phys_r !== ep) begin
      errors++;
      $display("FAIL %s: got hit=%0b tag=%h phys=%h exp hit=%0b tag=%h phys=%h",
               name, hit, accesstag_r, phys_r, eh, ea, ep);
    end
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b1;
    v.cmd = TLB_CMD_NONE; v.va = '0; v.acc = '0; v.phys = '0;
    v.eh = 1'b0; v.eacc = '0; v.ephys = '0;
    apply(v);

    inv(0); inv(1);
    rs(20'h00055, 0, 8'h00, 22'h0);
    wr(20'h00100, 8'hFF, 22'h0F5);
    wr(20'h00101, 8'hFF, 22'h0F5);
    wr(20'h00055, 8'hFF, 22'h0FE);
    wr(20'h00056, 8'hFF, 22'h0F5);
    rs(20'h00055, 1, 8'hFF, 22'h0FE);
    rs(20'h00056, 1, 8'hFF, 22'h0F5);
    rs(20'h00100, 1, 8'hFF, 22'h0F5);
    rs(20'h00101, 1, 8'hFF, 22'h0F5);
    // set 0 full, victim ptr 0 -> way0 (0x100) replaced
    wr(20'h00102, 8'hFF, 22'h0AA);
    rs(20'h00102, 1, 8'hFF, 22'h0AA);
    rs(20'h00100, 0, 8'h00, 22'h0);
    rs(20'h00056, 1, 8'hFF, 22'h0F5);
    wr(20'h00055, 8'h3C, 22'h033);
    rs(20'h00055, 1, 8'h3C, 22'h033);
    rs(20'h00101, 1, 8'hFF, 22'h0F5);
    // victim ptr now 1 -> way1 (0x56) replaced
    wr(20'h00104, 8'h42, 22'h077);
    rs(20'h00056, 0, 8'h00, 22'h0);
    rs(20'h00102, 1, 8'hFF, 22'h0AA);
    rs(20'h00104, 1, 8'h42, 22'h077);
    add(TLB_CMD_NONE, 20'h00104, 8'h0, 22'h0, 0, 8'h0, 22'h0);
    // ptr wraps to 0 -> way0 (0x102) replaced, ptr becomes 1
    wr(20'h00106, 8'h06, 22'h066);
    rs(20'h00102, 0, 8'h00, 22'h0);
    rs(20'h00106, 1, 8'h06, 22'h066);
    inv(0); inv(1);
    rs(20'h00055, 0, 8'h00, 22'h0);
    rs(20'h00056, 0, 8'h00, 22'h0);
    rs(20'h00100, 0, 8'h00, 22'h0);
    rs(20'h00101, 0, 8'h00, 22'h0);
    rs(20'h00104, 0, 8'h00, 22'h0);
    rs(20'h00106, 0, 8'h00, 22'h0);
    // refill set 0; invalidate reset ptr so way0 (0x100) goes
    wr(20'h00100, 8'hFF, 22'h0F5);
    wr(20'h00102, 8'hFF, 22'h0AA);
    wr(20'h00104, 8'h42, 22'h077);
    rs(20'h00100, 0, 8'h00, 22'h0);
    rs(20'h00102, 1, 8'hFF, 22'h0AA);
    rs(20'h00104, 1, 8'h42, 22'h077);

    repeat (2) @(negedge clk);
    chk("reset_state", 1'b0, 8'h00, 22'h0);
    rst_n = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].eh, vecs[i].eacc,
          vecs[i].ephys);
    end

    v.cmd = TLB_CMD_RESOLVE; v.va = 20'h00102;
    apply(v);
    @(posedge clk);
    #1 chk("pre_reset_hit", 1'b1, 8'hFF, 22'h0AA);
    #1 rst_n = 1'b1;
    #1 chk("reset_mid_lookup", 1'b0, 8'h00, 22'h0);
    @(negedge clk);
    v.cmd = TLB_CMD_NONE;
    apply(v);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    v.cmd = TLB_CMD_RESOLVE; v.va = 20'h00102;
    apply(v);
    @(negedge clk);
    chk("post_reset_miss_102", 1'b0, 8'h00, 22'h0);
    v.va = 20'h00104;
    apply(v);
    @(negedge clk);
    chk("post_reset_miss_104", 1'b0, 8'h00, 22'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
